// File: rtl/qbert_jump_ctrl.sv
// Q*bert hop sequencer: tracks the pyramid cube position and walks the sprite one pixel per
// motion tick toward the target cube, or off the pyramid edge when the hop leaves it.
module qbert_jump_ctrl #(
   parameter int unsigned ROWS     = 7,
   parameter logic [10:0] X_ORIGIN = 11'd100,
   parameter logic [9:0]  Y_ORIGIN = 10'd400,
   parameter logic [10:0] XSTEP    = 11'd60,
   parameter logic [9:0]  YHALF    = 10'd50,
   parameter logic [25:0] STEP_DIV = 26'd1000000,
   parameter logic [10:0] FALL_PIX = 11'd200
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        jump_req,
   input  logic [1:0]  jump_dir,
   input  logic        restart,
   output logic [10:0] pos_x,
   output logic [9:0]  pos_y,
   output logic [2:0]  row,
   output logic [2:0]  col,
   output logic        busy,
   output logic        hop_done,
   output logic        fell
);

   typedef enum logic [2:0] {
      S_IDLE, S_AXIS1, S_AXIS2, S_LAND, S_FALL, S_DEAD
   } state_t;

   localparam logic signed [3:0] ROWS_S = 4'(ROWS);

   state_t      state_q;
   logic [25:0] cnt_q, cnt_d;
   logic [10:0] pos_x_q, tx_q, fall_cnt_q;
   logic [9:0]  pos_y_q, ty_q;
   logic [2:0]  row_q, col_q, tr_q, tc_q;
   logic        down_q, busy_q, hop_done_q, fell_q;

   logic              tick;
   logic signed [3:0] tr_s, tc_s;
   logic signed [4:0] y_mult;
   logic              off_edge;
   logic [10:0]       tgt_x, nxt_x;
   logic [9:0]        tgt_y, nxt_y;
   logic              move_y, axis_done;

   assign tick  = (cnt_q == STEP_DIV - 26'd1);
   assign cnt_d = tick ? '0 : cnt_q + 26'd1;

   // Target cube from the current cube and direction; signed so an off-pyramid hop shows up as <0.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      tr_s = signed'({1'b0, row_q});
      tc_s = signed'({1'b0, col_q});
      unique case (jump_dir)
         2'b00:   tr_s = tr_s - 4'sd1;
         2'b01:   begin tr_s = tr_s - 4'sd1; tc_s = tc_s - 4'sd1; end
         2'b10:   begin tr_s = tr_s + 4'sd1; tc_s = tc_s + 4'sd1; end
         default: tr_s = tr_s + 4'sd1;
      endcase
      off_edge = (tr_s < 4'sd0) || (tr_s >= ROWS_S) || (tc_s < 4'sd0) || (tc_s > tr_s);
      y_mult   = {tc_s, 1'b0} - {tr_s[3], tr_s};
      tgt_x    = X_ORIGIN + XSTEP * {8'd0, tr_s[2:0]};
      tgt_y    = Y_ORIGIN + {{5{y_mult[4]}}, y_mult} * YHALF;
   end

   // Down hops move y first, up hops move x first.
   always_comb begin
      move_y = ((state_q == S_AXIS1) == down_q);
      nxt_x  = pos_x_q;
      nxt_y  = pos_y_q;
      if (move_y) begin
         if (pos_y_q < ty_q)      nxt_y = pos_y_q + 10'd1;
         else if (pos_y_q > ty_q) nxt_y = pos_y_q - 10'd1;
      end else begin
         if (pos_x_q < tx_q)      nxt_x = pos_x_q + 11'd1;
         else if (pos_x_q > tx_q) nxt_x = pos_x_q - 11'd1;
      end
      axis_done = move_y ? (nxt_y == ty_q) : (nxt_x == tx_q);
   end

   always_ff @(posedge clk) begin
      // NOTE: all state updates are non-blocking so every register samples pre-edge values.
      if (reset || restart) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         pos_x_q    <= X_ORIGIN;
         pos_y_q    <= Y_ORIGIN;
         tx_q       <= X_ORIGIN;
         ty_q       <= Y_ORIGIN;
         row_q      <= '0;
         col_q      <= '0;
         tr_q       <= '0;
         tc_q       <= '0;
         fall_cnt_q <= '0;
         down_q     <= 1'b0;
         busy_q     <= 1'b0;
         hop_done_q <= 1'b0;
         fell_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         hop_done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (jump_req) begin
                  cnt_q  <= '0;
                  busy_q <= 1'b1;
                  if (off_edge) begin
                     state_q    <= S_FALL;
                     fell_q     <= 1'b1;
                     fall_cnt_q <= '0;
                  end else begin
                     state_q <= S_AXIS1;
                     tr_q    <= tr_s[2:0];
                     tc_q    <= tc_s[2:0];
                     tx_q    <= tgt_x;
                     ty_q    <= tgt_y;
                     down_q  <= (tgt_x > pos_x_q);
                  end
               end
            end
            S_AXIS1: begin
               if (tick) begin
                  pos_x_q <= nxt_x;
                  pos_y_q <= nxt_y;
                  if (axis_done) state_q <= S_AXIS2;
               end
            end
            S_AXIS2: begin
               if (tick) begin
                  pos_x_q <= nxt_x;
                  pos_y_q <= nxt_y;
                  if (axis_done) begin
                     state_q    <= S_LAND;
                     hop_done_q <= 1'b1;
                     row_q      <= tr_q;
                     col_q      <= tc_q;
                  end
               end
            end
            S_LAND: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            S_FALL: begin
               if (tick) begin
                  pos_x_q    <= pos_x_q + 11'd1;
                  fall_cnt_q <= fall_cnt_q + 11'd1;
                  if (fall_cnt_q == FALL_PIX - 11'd1) state_q <= S_DEAD;
               end
            end
            S_DEAD: ;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign pos_x    = pos_x_q;
   assign pos_y    = pos_y_q;
   assign row      = row_q;
   assign col      = col_q;
   assign busy     = busy_q;
   assign hop_done = hop_done_q;
   assign fell     = fell_q;

endmodule

// File: tb/tb_qbert_jump_ctrl.sv
// Bench for qbert_jump_ctrl: a trajectory-planning model predicts every cycle's outputs,
// and directed hops add hand-computed literal expectations.
module tb_qbert_jump_ctrl;

   localparam int SD = 2;
   localparam int FP = 200;

   logic        clk = 1'b0;
   logic        reset, jump_req, restart;
   logic [1:0]  jump_dir;
   logic [10:0] pos_x;
   logic [9:0]  pos_y;
   logic [2:0]  row, col;
   logic        busy, hop_done, fell;

   qbert_jump_ctrl #(.STEP_DIV(26'd2)) dut (
      .clk(clk), .reset(reset), .jump_req(jump_req), .jump_dir(jump_dir), .restart(restart),
      .pos_x(pos_x), .pos_y(pos_y), .row(row), .col(col),
      .busy(busy), .hop_done(hop_done), .fell(fell)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x; int y; int row; int col;
      bit busy; bit hop_done; bit fell;
   } snap_t;

   snap_t cur;
   snap_t sched[$];
   int    errors = 0;
   int    checks = 0;
   int    hop_cnt = 0;
   bit    cmp_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic snap_t home();
      snap_t s;
      s.x = 100; s.y = 400; s.row = 0; s.col = 0;
      s.busy = 1'b0; s.hop_done = 1'b0; s.fell = 1'b0;
      return s;
   endfunction

   // Expands a hop into one expected snapshot per clock cycle after the accepting edge.
   task automatic plan_hop(input logic [1:0] d);
      int tr, tc, tx, ty, x, y, nt;
      bit down;
      snap_t s;
      int xp[$];
      int yp[$];
      tr = cur.row; tc = cur.col;
      case (d)
         2'b00:   tr--;
         2'b01:   begin tr--; tc--; end
         2'b10:   begin tr++; tc++; end
         default: tr++;
      endcase
      s = cur; s.busy = 1'b1; s.hop_done = 1'b0;
      if (tr < 0 || tr >= 7 || tc < 0 || tc > tr) begin
         s.fell = 1'b1;
         for (int k = 0; k <= SD*FP; k++) begin
            s.x = cur.x + k/SD;
            sched.push_back(s);
         end
      end else begin
         tx = 100 + tr*60;
         ty = 400 + (2*tc - tr)*50;
         x = cur.x; y = cur.y; down = (tx > x);
         xp.push_back(x); yp.push_back(y);
         for (int a = 0; a < 2; a++) begin
            if ((a == 0) == down) begin
               if (y == ty) begin xp.push_back(x); yp.push_back(y); end
               while (y != ty) begin y += (ty > y) ? 1 : -1; xp.push_back(x); yp.push_back(y); end
            end else begin
               if (x == tx) begin xp.push_back(x); yp.push_back(y); end
               while (x != tx) begin x += (tx > x) ? 1 : -1; xp.push_back(x); yp.push_back(y); end
            end
         end
         nt = xp.size() - 1;
         for (int k = 0; k <= SD*nt; k++) begin
            s.x = xp[k/SD]; s.y = yp[k/SD];
            s.hop_done = (k == SD*nt);
            sched.push_back(s);
         end
         s.busy = 1'b0; s.hop_done = 1'b0; s.row = tr; s.col = tc;
         sched.push_back(s);
      end
   endtask

   initial forever begin
      @(posedge clk);
      if (reset || restart) begin
         cur = home();
         sched.delete();
         cmp_en = 1'b1;
      end else if (sched.size() > 0) begin
         cur = sched.pop_front();
      end else if (!cur.busy && jump_req) begin
         plan_hop(jump_dir);
         cur = sched.pop_front();
      end
   end

   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         check("m_pos_x", pos_x, cur.x);
         check("m_pos_y", pos_y, cur.y);
         check("m_busy", busy, cur.busy);
         check("m_fell", fell, cur.fell);
         check("m_hop_done", hop_done, cur.hop_done);
         if (!cur.busy) begin
            check("m_row", row, cur.row);
            check("m_col", col, cur.col);
         end
         if (hop_done === 1'b1) hop_cnt++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_jump(input logic [1:0] d);
      jump_dir = d; jump_req = 1'b1;
      @(negedge clk);
      jump_req = 1'b0;
   endtask

   task automatic wait_hop(input int budget, output int n);
      n = 0;
      while (hop_done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) check("hop_done_timeout", hop_done, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, h0;
      reset = 1'b1; restart = 1'b0; jump_req = 1'b0; jump_dir = 2'b00;
      cyc(3);
      check("t1_pos_x", pos_x, 100);
      check("t1_pos_y", pos_y, 400);
      check("t1_busy", busy, 0);
      reset = 1'b0;
      cyc(1);
      check("t1_row", row, 0);
      check("t1_fell", fell, 0);

      // Down-right hop (0,0)->(1,1): y first, then x.
      pulse_jump(2'b10);
      check("t2_busy_rise", busy, 1);
      cyc(20);
      check("t2_mid_y", pos_y, 410);
      check("t2_mid_x", pos_x, 100);
      wait_hop(1000, n);
      check("t2_latency", n, 200);
      check("t2_land_x", pos_x, 160);
      check("t2_land_y", pos_y, 450);
      cyc(1);
      check("t2_busy_low", busy, 0);
      check("t2_row", row, 1);
      check("t2_col", col, 1);

      // Up-right from (1,1) leaves the pyramid.
      pulse_jump(2'b00);
      check("t3_fell", fell, 1);
      cyc(SD*FP);
      check("t3_dead_x", pos_x, 360);
      check("t3_dead_y", pos_y, 450);
      pulse_jump(2'b10);
      cyc(10);
      check("t3_hold_x", pos_x, 360);
      check("t3_hold_busy", busy, 1);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      check("t3_rst_x", pos_x, 100);
      check("t3_rst_y", pos_y, 400);
      check("t3_rst_fell", fell, 0);

      // Mid-hop request is ignored.
      h0 = hop_cnt;
      pulse_jump(2'b10);
      cyc(20);
      pulse_jump(2'b11);
      wait_hop(1000, n);
      cyc(3);
      check("t4_one_hop", hop_cnt - h0, 1);
      check("t4_row", row, 1);
      check("t4_col", col, 1);

      // Up-left (1,1)->(0,0): x first.
      pulse_jump(2'b01);
      cyc(20);
      check("t4b_mid_x", pos_x, 150);
      check("t4b_mid_y", pos_y, 450);
      wait_hop(1000, n);
      cyc(1);
      check("t4b_row", row, 0);

      // Reset during the second axis.
      pulse_jump(2'b10);
      cyc(120);
      check("t5_axis2_x", pos_x, 110);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t5_x", pos_x, 100);
      check("t5_y", pos_y, 400);
      check("t5_busy", busy, 0);
      h0 = hop_cnt;
      cyc(300);
      check("t5_no_hop", hop_cnt - h0, 0);

      // Restart beats a simultaneous jump request at (1,0).
      pulse_jump(2'b11);
      wait_hop(1000, n);
      check("t6_land_y", pos_y, 350);
      cyc(1);
      check("t6_col", col, 0);
      jump_dir = 2'b10; jump_req = 1'b1; restart = 1'b1;
      @(negedge clk);
      jump_req = 1'b0; restart = 1'b0;
      check("t6_busy", busy, 0);
      check("t6_x", pos_x, 100);
      check("t6_y", pos_y, 400);
      cyc(10);
      check("t6_still_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
